// File: rtl/text_pkg.sv
// text_pkg: shared control codes, default screen geometry and FSM encoding for text_writer.
package text_pkg;
    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 30;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_TILDE = 8'h7E;
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
    function automatic logic is_printable(input logic [7:0] c);
        return c >= CHR_SPACE && c <= CHR_TILDE;
    endfunction
endpackage

// File: rtl/cursor_tracker.sv
// cursor_tracker: holds the text cursor and the RAM base address of its row, wrapping at COLS/ROWS.
module cursor_tracker
    import text_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              home_col_i,
    input  logic              next_row_i,
    input  logic              home_all_i,
    output logic [5:0]        col_o,
    output logic [4:0]        row_o,
    output logic [ADDR_W-1:0] row_base_o
);
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] rb_q, rb_d;
    logic              last_col, last_row, adv;
    assign last_col = col_q == 6'(COLS - 1);
    assign last_row = row_q == 5'(ROWS - 1);
    // a printable in the last column advances the row just like LF
    assign adv      = next_row_i || (inc_i && last_col);
    always_comb begin
        col_d = (home_all_i || adv || home_col_i) ? '0 :
                inc_i ? col_q + 6'd1 :
                (dec_i && col_q != '0) ? col_q - 6'd1 : col_q;
        row_d = (home_all_i || (adv && last_row)) ? '0 : adv ? row_q + 5'd1 : row_q;
        rb_d  = (home_all_i || (adv && last_row)) ? '0 : adv ? rb_q + ADDR_W'(COLS) : rb_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
            rb_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            rb_q  <= rb_d;
        end
    end
    assign col_o      = col_q;
    assign row_o      = row_q;
    assign row_base_o = rb_q;
endmodule

// File: rtl/text_writer.sv
// text_writer: terminal-style byte sink driving the character RAM write port, with cursor,
// control codes and full/row blanking sequences.
module text_writer
    import text_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              px_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(COLS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d, waddr_q, waddr_d, row_base;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [5:0]          col;
    logic [4:0]          row;
    logic                accept, prt, is_cr, is_lf, is_bs, is_ff, wrap, clr_done;
    logic                inc, dec, home_col, next_row, home_all;

    assign accept   = in_valid && state_q == IDLE;
    assign prt      = is_printable(in_data);
    assign is_cr    = in_data == CHR_CR;
    assign is_lf    = in_data == CHR_LF;
    assign is_bs    = in_data == CHR_BS;
    assign is_ff    = in_data == CHR_FF;
    assign wrap     = prt && col == 6'(COLS - 1);
    assign clr_done = (state_q == CLR_ALL) ? cnt_q == LAST_ALL : cnt_q == LAST_ROW;

    cursor_tracker #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
        .clk_i      (px_clk),
        .rst_ni     (rst_n),
        .inc_i      (inc),
        .dec_i      (dec),
        .home_col_i (home_col),
        .next_row_i (next_row),
        .home_all_i (home_all),
        .col_o      (col),
        .row_o      (row),
        .row_base_o (row_base)
    );

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_ALL;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = (state_q != IDLE) ? (clr_done ? IDLE : state_q) :
                  !accept ? IDLE :
                  (wrap || is_lf) ? CLR_ROW :
                  is_ff ? CLR_ALL : IDLE;
    end

    always_comb begin
        cnt_d    = (state_q != IDLE && !clr_done) ? cnt_q + 1'b1 : '0;
        inc      = accept && prt;
        dec      = accept && is_bs && col != '0;
        home_col = accept && is_cr;
        next_row = accept && is_lf;
        home_all = state_q == CLR_ALL && clr_done;
        we_d     = state_q != IDLE || inc || dec;
        // row_base already points at the new row by the time CLR_ROW runs
        waddr_d  = (state_q == CLR_ALL) ? cnt_q :
                   (state_q == CLR_ROW) ? row_base + cnt_q :
                   row_base + ADDR_W'(dec ? col - 6'd1 : col);
        wdata_d  = inc ? in_data : DATA_W'(CHR_SPACE);
    end

    assign in_ready   = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign write_en   = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign cursor_col = col;
    assign cursor_row = row;
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed self-checking bench for text_writer.
module tb_text_writer;
    logic        px_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, write_en, busy;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    int tests = 0;
    int fails = 0;

    text_writer dut (
        .px_clk     (px_clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .write_en   (write_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge px_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge px_clk);
            n++;
        end
        chk(tag, 32'(in_ready), 1);
    endtask

    task automatic clear_check(input string tag, input int base, input int n);
        int bad = 0;
        int rdy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge px_clk);
            if (!(write_en === 1'b1 && waddr === 11'(base + i) && wdata === 8'h20)) bad++;
            if (in_ready) rdy++;
        end
        chk({tag, "_writes"}, bad, 0);
        chk({tag, "_ready_cnt"}, rdy, 1);
        chk({tag, "_ready_end"}, 32'(in_ready), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, 32'(write_en), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wdata"}, 32'(wdata), 0);
        chk({tag, "_ready_busy"}, {30'd0, in_ready, busy}, 32'b01);
        chk({tag, "_cursor"}, {21'd0, cursor_row, cursor_col}, 0);
    endtask

    initial begin
        int bad;
        @(negedge px_clk);
        @(negedge px_clk);
        chk_reset("rst");
        rst_n = 1'b1;
        clear_check("clr_all", 0, 1200);
        chk("clr_all_cursor", {21'd0, cursor_row, cursor_col}, 0);
        chk("clr_all_busy", 32'(busy), 0);

        send(8'h41);
        chk("A_write", {write_en, waddr, wdata}, {1'b1, 11'd0, 8'h41});
        chk("A_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd0, 6'd1});
        send(8'h0D);
        chk("cr_nowrite", 32'(write_en), 0);
        chk("cr_col", 32'(cursor_col), 0);

        bad = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data = 8'h30 + 8'(k);
            @(negedge px_clk);
            if (!(write_en === 1'b1 && waddr === 11'(k) && wdata === 8'h30 + 8'(k))) bad++;
        end
        in_valid = 1'b0;
        chk("stream_writes", bad, 0);
        chk("stream_busy", {30'd0, in_ready, busy}, 32'b01);
        chk("stream_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd1, 6'd0});
        clear_check("clr_row1", 40, 40);

        for (int r = 0; r < 28; r++) begin
            send(8'h0A);
            wait_ready("lf_ready");
        end
        chk("row29", 32'(cursor_row), 29);
        for (int k = 0; k < 5; k++) send(8'h61 + 8'(k));
        chk("row29_write", {write_en, waddr, wdata}, {1'b1, 11'd1164, 8'h65});
        chk("row29_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd29, 6'd5});
        send(8'h0A);
        chk("wrap_lf", {write_en, busy}, 32'b01);
        chk("wrap_cursor", {21'd0, cursor_row, cursor_col}, 0);
        clear_check("clr_wrap", 0, 40);
        send(8'h0D);
        chk("cr2_nowrite", 32'(write_en), 0);

        send(8'h0A);
        wait_ready("lf_r1");
        send(8'h0A);
        wait_ready("lf_r2");
        send(8'h31);
        send(8'h32);
        send(8'h33);
        chk("pre_bs_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd2, 6'd3});
        send(8'h08);
        chk("bs_write", {write_en, waddr, wdata}, {1'b1, 11'd82, 8'h20});
        chk("bs_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd2, 6'd2});
        send(8'h0D);
        send(8'h08);
        chk("bs0_nowrite", 32'(write_en), 0);
        chk("bs0_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd2, 6'd0});
        send(8'h01);
        chk("ctl_ignored", {write_en, 5'd0, cursor_col}, 0);
        send(8'h7F);
        chk("del_ignored", {write_en, 5'd0, cursor_col}, 0);
        send(8'h7E);
        chk("tilde_write", {write_en, waddr, wdata}, {1'b1, 11'd80, 8'h7E});

        send(8'h0C);
        chk("ff_start", {write_en, busy}, 32'b01);
        repeat (600) @(negedge px_clk);
        chk("ff_mid", {write_en, waddr, wdata}, {1'b1, 11'd599, 8'h20});
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge px_clk);
        rst_n = 1'b1;
        clear_check("clr_again", 0, 1200);
        chk("clr_again_cursor", {21'd0, cursor_row, cursor_col}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
